add_sub_logic_alu: RTL and testbench
====================================

Name: add_sub_logic_alu

Overview:
- Small registered ALU for the datapath.
- Each accepted operation selects one of four functions on two WIDTH-bit operands: add, subtract, unsigned greater-than compare, or bitwise invert of b.
- Result and status flags are registered, with one-cycle latency and a valid strobe.
- Used wherever a single add/sub/compare/not stage is needed in a clocked pipeline.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  op/a/b are valid this cycle; accepted on every cycle it is high.
- op  input  2  function select: 0 = add, 1 = sub, 2 = greater-than, 3 = not-b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  r and flags hold a new result.
- r  output  WIDTH  result.
- carry  output  1  carry out of add, or borrow-free indication of sub.
- overflow  output  1  two's-complement signed overflow of add or sub.
- zero  output  1  r == 0.
- negative  output  1  MSB of r.

Behaviour:
- The interface is fixed: one clock (clk), and reset is synchronous and active-high (reset).
- Reset:
  - On a clk edge with reset=1, out_valid, r, carry, overflow, zero and negative all become 0.
  - in_valid is ignored during that edge.
  - If reset is asserted mid-stream, any result in flight is discarded.
- Latency and handshake:
  - When in_valid=1 at a clk edge (and reset=0), the result of op/a/b is registered.
  - out_valid=1 in the following cycle, so latency is 1 cycle.
  - One result per cycle is possible. There is no backpressure.
  - When in_valid=0, out_valid drops to 0 on the next edge, and r and the flags hold their previous values.
- Arithmetic, all modulo 2^WIDTH:
  - op 0: r = a + b. carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow = sign(a)==sign(b) and sign(r)!=sign(a).
  - op 1: r = a - b, computed as a + ~b + 1. carry = 1 when a >= b (unsigned, no borrow). overflow = sign(a)!=sign(b) and sign(r)!=sign(a).
  - op 2: r = 1 if a > b (unsigned), else r = 0. The upper WIDTH-1 bits are always 0. carry = 0, overflow = 0. Equal operands give r = 0.
  - op 3: r = ~b (bitwise invert of b; a is ignored). carry = 0, overflow = 0.
- Flags:
  - zero and negative are derived from the registered r for every op.
  - zero = (r == 0) and negative = r[WIDTH-1], both updated in the same edge as r.
- Wrap-around examples (WIDTH=16):
  - 0xFFFF + 1 gives r = 0x0000, carry = 1, zero = 1.
  - 100 - 200 gives r = 0xFF9C, carry = 0, negative = 1.
- Datapath: purely synchronous. No combinational path from inputs to outputs. Inputs are not required to be stable outside the sampling edge.

Test Plan:
- Reset: hold reset for 2 cycles with in_valid=1 and op=0, a=1, b=1 → out_valid=0, r=0, all flags 0. Release reset → the next accepted op produces a result 1 cycle later.
- Add: op=0, a=2, b=3 → r=5 next cycle. a=100, b=200 → r=300. a=0xFFFF, b=1 → r=0, carry=1, zero=1. a=0x7FFF, b=1 → r=0x8000, overflow=1, negative=1.
- Subtract: op=1, a=10, b=5 → r=5, carry=1. a=100, b=200 → r=0xFF9C, carry=0, negative=1. a=0x8000, b=1 → overflow=1.
- Compare: op=2, a=7, b=11 → r=0, zero=1. a=11, b=7 → r=1. a=b=42 → r=0.
- Invert: op=3, a=3, b=10 → r=0xFFF5. a=10, b=3 → r=0xFFFC. b=0xFFFF → r=0, zero=1.
- Streaming and gaps: back-to-back in_valid for 4 cycles with mixed ops → 4 consecutive out_valid cycles with correct results in order. Then deassert in_valid → out_valid=0 next cycle and r holds its last value.

Source files
------------

// File: rtl/add_sub_logic_alu.sv
// Registered four-function ALU: add, subtract, unsigned greater-than, invert-b.
// Result and status flags appear one cycle after an accepted operation.
module add_sub_logic_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_GT  = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    logic [WIDTH-1:0] b_eff_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] r_next_c;
    logic             carry_next_c;
    logic             overflow_next_c;

    // Shared adder: subtraction is a + ~b + 1, so one carry chain serves both ops.
    always_comb begin
        b_eff_c = (op == OP_SUB) ? ~b : b;
        sum_c   = {1'b0, a} + {1'b0, b_eff_c} + (WIDTH+1)'(op == OP_SUB);
    end

    always_comb begin
        r_next_c        = '0;
        carry_next_c    = 1'b0;
        overflow_next_c = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                r_next_c        = sum_c[WIDTH-1:0];
                carry_next_c    = sum_c[WIDTH];
                overflow_next_c = (a[MSB] == b_eff_c[MSB]) && (sum_c[MSB] != a[MSB]);
            end
            OP_GT:   r_next_c = WIDTH'(a > b);
            OP_NOT:  r_next_c = ~b;
            default: r_next_c = '0;
        endcase
    end

    // Output registers; r and flags hold when no operation is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            r         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r        <= r_next_c;
                carry    <= carry_next_c;
                overflow <= overflow_next_c;
                zero     <= (r_next_c == '0);
                negative <= r_next_c[MSB];
            end
        end
    end

endmodule

// File: tb/tb_add_sub_logic_alu.sv
// Bench for add_sub_logic_alu: directed cases plus random traffic against an
// arithmetic reference model built from integer add/subtract/compare.
module tb_add_sub_logic_alu;

    localparam int unsigned W = 16;
    localparam longint FULL = longint'(1) << W;
    localparam longint HALF = longint'(1) << (W - 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] r;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    int n_cmp = 0;
    int n_bad = 0;

    longint m_valid, m_r, m_c, m_o, m_z, m_n;

    add_sub_logic_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .r(r), .carry(carry), .overflow(overflow),
        .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint to_signed(input longint x);
        return (x >= HALF) ? x - FULL : x;
    endfunction

    // Reference behaviour: what the registered outputs should be after this edge.
    task automatic model(input bit rst, input bit v, input int o, input longint x, input longint y);
        longint res, s;
        if (rst) begin
            m_valid = 0; m_r = 0; m_c = 0; m_o = 0; m_z = 0; m_n = 0;
            return;
        end
        m_valid = v;
        if (!v) return;
        m_c = 0;
        m_o = 0;
        case (o)
            0: begin
                res = x + y;
                m_c = (res >= FULL);
                s = to_signed(x) + to_signed(y);
                m_o = (s >= HALF) || (s < -HALF);
            end
            1: begin
                res = x - y;
                m_c = (x >= y);
                s = to_signed(x) - to_signed(y);
                m_o = (s >= HALF) || (s < -HALF);
            end
            2: res = (x > y) ? 1 : 0;
            default: res = FULL - 1 - y;
        endcase
        res = ((res % FULL) + FULL) % FULL;
        m_r = res;
        m_z = (res == 0);
        m_n = (res >= HALF);
    endtask

    task automatic step(input bit rst, input bit v, input int o, input longint x, input longint y);
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        op       = 2'(o);
        a        = W'(x);
        b        = W'(y);
        @(posedge clk);
        model(rst, v, o, x, y);
        #1;
        check("out_valid", longint'(out_valid), m_valid);
        check("r",         longint'(r),         m_r);
        check("carry",     longint'(carry),     m_c);
        check("overflow",  longint'(overflow),  m_o);
        check("zero",      longint'(zero),      m_z);
        check("negative",  longint'(negative),  m_n);
    endtask

    // Directed check of a single result against hand-computed values.
    task automatic expect_r(input string tag, input longint er);
        check(tag, longint'(r), er);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        m_valid = 0; m_r = 0; m_c = 0; m_o = 0; m_z = 0; m_n = 0;

        step(1, 1, 0, 1, 1);
        step(1, 1, 0, 1, 1);

        step(0, 1, 0, 2, 3);           expect_r("add_2_3", 5);
        step(0, 1, 0, 100, 200);       expect_r("add_100_200", 300);
        step(0, 1, 0, 16'hFFFF, 1);    expect_r("add_wrap", 0);
        check("add_wrap_carry", longint'(carry), 1);
        step(0, 1, 0, 16'h7FFF, 1);    expect_r("add_ovf", 16'h8000);
        check("add_ovf_flag", longint'(overflow), 1);
        step(0, 1, 1, 10, 5);          expect_r("sub_10_5", 5);
        step(0, 1, 1, 100, 200);       expect_r("sub_neg", 16'hFF9C);
        check("sub_neg_carry", longint'(carry), 0);
        step(0, 1, 1, 16'h8000, 1);    check("sub_ovf_flag", longint'(overflow), 1);
        step(0, 1, 2, 7, 11);          expect_r("gt_lt", 0);
        step(0, 1, 2, 11, 7);          expect_r("gt_gt", 1);
        step(0, 1, 2, 42, 42);         expect_r("gt_eq", 0);
        step(0, 1, 3, 3, 10);          expect_r("not_10", 16'hFFF5);
        step(0, 1, 3, 10, 3);          expect_r("not_3", 16'hFFFC);
        step(0, 1, 3, 0, 16'hFFFF);    expect_r("not_ffff", 0);

        step(0, 1, 0, 1000, 234);
        step(0, 1, 1, 5, 9);
        step(0, 1, 2, 9, 5);
        step(0, 1, 3, 0, 16'h00F0);
        step(0, 0, 0, 7, 7);           expect_r("hold_r", 16'hFF0F);
        step(0, 0, 1, 1, 2);

        // Random traffic with gaps and occasional mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            longint x, y;
            int sel;
            sel = int'($urandom_range(0, 3));
            x = (sel == 0) ? longint'($urandom_range(0, 3) * 16'h4000 + $urandom_range(0, 1))
                           : longint'($urandom_range(0, 16'hFFFF));
            y = (sel == 1) ? x : longint'($urandom_range(0, 16'hFFFF));
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)), x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
